bcd_display_scanner: RTL and testbench

//  Upstream feeder for the 4-bit BCD-to-seven-segment decoder. Holds a 4-digit packed BCD value and

---
 rtl/bcd_display_scanner.sv | 146 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Purpose:
//   This module feeds a single shared BCD-to-seven-segment decoder. It holds a
//   4-digit packed BCD value and time-multiplexes it across four digits. Each
//   digit slot puts that slot's nibble on bcd and pulls that digit's
//   active-low anode low.
//
//   A newly loaded value takes effect only at a frame boundary. A frame
//   therefore never shows a mix of old and new digits.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLANK_CYC    cycles at the start of each slot with all anodes off
//                (ghost suppression), 0..REFRESH_DIV-1
//   CNT_W        prescaler width, 2**CNT_W >= REFRESH_DIV
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous reset, active-high
//   load   in   1   1-cycle strobe: capture din
//   din    in   16  packed BCD, digit3 = din[15:12] .. digit0 = din[3:0]
//   bcd    out  4   nibble for decoder inputs s3..s0
//   an     out  4   digit anode enables, active-low, at most one low
//   frame  out  1   1-cycle pulse the cycle after every frame boundary
//   err    out  1   high while the active value holds any nibble > 9
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, digits 3..1 are dark while that digit and every higher digit
//   are zero. Digit 0 is always shown.
//
// Load handshake:
//   load is a strobe with no ready/back-pressure. Every cycle with load=1 is
//   accepted. din is captured into a pending register, and a later load
//   overwrites it. The pending value is promoted to the displayed value at the
//   next frame boundary. A load on the boundary cycle itself is written
//   straight to the displayed value.
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        frame,
  output logic        err
);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      active;
  logic [15:0]      pending;
  logic             pend_vld;

  logic             tick;
  logic             boundary;
  logic [15:0]      active_nxt;
  logic [3:0]       nib;
  logic             nib_bad;
  logic             slot_blank;
  logic             lz_blank;

  function automatic logic has_bad_nibble(input logic [15:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign tick     = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign boundary = tick && (idx == 2'd3);

  // A load on the boundary cycle bypasses pending. This keeps the newest value
  // from waiting a whole extra frame.
  always_comb begin
    active_nxt = active;
    if (boundary) begin
      if (load)          active_nxt = din;
      else if (pend_vld) active_nxt = pending;
    end
  end

  assign nib        = active[{idx, 2'b00} +: 4];
  assign nib_bad    = (nib > 4'd9);
  assign slot_blank = (cnt < CNT_W'(BLANK_CYC));

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark while it and all higher digits are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (idx)
      2'd3:    lz_blank = (active[15:12] == 4'd0);
      2'd2:    lz_blank = (active[15:8]  == 8'd0);
      2'd1:    lz_blank = (active[15:4]  == 12'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      active   <= 16'h0000;
      pending  <= 16'h0000;
      pend_vld <= 1'b0;
      bcd      <= 4'h0;
      an       <= 4'hF;
      frame    <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Prescaler and digit index
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Pending value: last load wins, and the boundary always consumes it.
      if (load) pending <= din;
      if (boundary)  pend_vld <= 1'b0;
      else if (load) pend_vld <= 1'b1;

      active <= active_nxt;
      err    <= has_bad_nibble(active_nxt);

      // Outputs reflect this cycle's idx/cnt, so they lag by one cycle.
      // An invalid nibble is shown as 0, and its anode stays off all slot.
      bcd   <= nib_bad ? 4'h0 : nib;
      an    <= (slot_blank || nib_bad || lz_blank) ? 4'hF : ~(4'b0001 << idx);
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scanner
//
// Bench for bcd_display_scanner, with REFRESH_DIV=4 and BLANK_CYC=1, so one
// frame is 16 cycles.
//
// Each entry of the frame table gives two things for one frame:
//   - the loads applied during that frame;
//   - the value that must be displayed during that frame.
//
// Each cycle, the expected {bcd, an, frame, err} is derived from the displayed
// value and the position in the frame. It is pushed when inputs are driven and
// popped after the next clock edge.
// -----------------------------------------------------------------------------
module tb_bcd_display_scanner;

  localparam int RD = 4;
  localparam int BC = 1;
  localparam int NF = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic [15:0] exp_val;
    int          pos [3];
    logic [15:0] dv  [3];
  } frame_vec_t;

  frame_vec_t fv [NF];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bcd_display_scanner #(
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC),
    .CNT_W      (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .din  (din),
    .bcd  (bcd),
    .an   (an),
    .frame(frame),
    .err  (err)
  );

  // ---------------- expected-value model ----------------
  function automatic logic bad_val(input logic [15:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) b = 1'b1;
    end
    return b;
  endfunction

  // Expected outputs sampled after the edge ending cycle 'pos' of a frame
  // showing 'val'. 'nxt' is the value shown in the following frame.
  function automatic logic [9:0] model(input logic [15:0] val, input int pos,
                                       input logic [15:0] nxt);
    int         slot;
    int         c;
    logic [3:0] nib;
    logic [3:0] b;
    logic [3:0] a;
    logic [3:0] one;
    logic       dark;
    logic       e;

    slot = pos / RD;
    c    = pos % RD;
    nib  = val[4*slot +: 4];
    dark = (c < BC) || (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && (val >> (4*slot)) == 16'h0000) dark = 1'b1;
`endif
    b   = (nib > 4'd9) ? 4'h0 : nib;
    one = 4'b0001;
    a   = dark ? 4'hF : ~(one << slot);
    e   = (pos == 15) ? bad_val(nxt) : bad_val(val);
    return {b, a, (pos == 15), e};
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic do_cycle(input string name, input logic ld, input logic [15:0] d,
                          input logic r, input logic [9:0] e);
    logic [9:0] got;
    logic [9:0] ex;
    load = ld;
    din  = d;
    rst  = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {bcd, an, frame, err};
    ex  = exp_q.pop_front();
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s t=%0t: got bcd=%h an=%h frame=%b err=%b, expected bcd=%h an=%h frame=%b err=%b",
               name, $time, got[9:6], got[5:2], got[1], got[0],
               ex[9:6], ex[5:2], ex[1], ex[0]);
    end
  endtask

  task automatic set_fv(input int i, input logic [15:0] v,
                        input int p0, input logic [15:0] d0,
                        input int p1, input logic [15:0] d1,
                        input int p2, input logic [15:0] d2);
    fv[i].exp_val = v;
    fv[i].pos[0] = p0; fv[i].dv[0] = d0;
    fv[i].pos[1] = p1; fv[i].dv[1] = d1;
    fv[i].pos[2] = p2; fv[i].dv[2] = d2;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic        ld;
    logic [15:0] d;
    logic [15:0] nxt;
    logic [9:0]  rst_exp;

    rst_exp = {4'h0, 4'hF, 1'b0, 1'b0};

    // Frame table: shown value, then up to three (position, din) loads.
    set_fv(0, 16'h0000, -1, 16'h0,     -1, 16'h0,     -1, 16'h0);     // idle
    set_fv(1, 16'h0000,  5, 16'h1234,  -1, 16'h0,     -1, 16'h0);     // load mid-frame
    set_fv(2, 16'h1234,  3, 16'h1111,   8, 16'h2222,  15, 16'h5678);  // last wins + boundary load
    set_fv(3, 16'h5678,  2, 16'h12A4,  -1, 16'h0,     -1, 16'h0);     // invalid nibble
    set_fv(4, 16'h12A4,  6, 16'h0009,  -1, 16'h0,     -1, 16'h0);     // clears err
    set_fv(5, 16'h0009,  1, 16'h0050,  -1, 16'h0,     -1, 16'h0);
    set_fv(6, 16'h0050, -1, 16'h0,     -1, 16'h0,     -1, 16'h0);     // leading zeros

    load = 1'b0;
    din  = 16'h0000;
    rst  = 1'b1;
    @(posedge clk);
    do_cycle("reset_state", 1'b0, 16'h0, 1'b1, rst_exp);
    do_cycle("reset_state", 1'b0, 16'h0, 1'b1, rst_exp);

    for (int f = 0; f < NF; f++) begin
      nxt = (f < NF - 1) ? fv[f+1].exp_val : fv[f].exp_val;
      for (int p = 0; p < 16; p++) begin
        ld = 1'b0;
        d  = 16'h0000;
        for (int j = 0; j < 3; j++) begin
          if (fv[f].pos[j] == p) begin
            ld = 1'b1;
            d  = fv[f].dv[j];
          end
        end
        do_cycle($sformatf("frame%0d_pos%0d", f, p), ld, d, 1'b0,
                 model(fv[f].exp_val, p, nxt));
      end
    end

    // Reset mid-slot-2 while a load is pending. The pending value is lost.
    for (int p = 0; p < 9; p++) begin
      do_cycle($sformatf("prerst_pos%0d", p), (p == 5), 16'h4321, 1'b0,
               model(16'h0050, p, 16'h0050));
    end
    do_cycle("midframe_reset", 1'b0, 16'h0, 1'b1, rst_exp);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 16; p++) begin
        do_cycle($sformatf("postrst%0d_pos%0d", f, p), 1'b0, 16'h0, 1'b0,
                 model(16'h0000, p, 16'h0000));
      end
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
